// File: rtl/phase_shift_bank_if.sv
// rtl/phase_shift_bank_if.sv - configuration write bus for phase_shift_bank (cfg_inv present with PHASE_SHIFT_INV_EN)
interface phase_shift_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_phase;
`ifdef PHASE_SHIFT_INV_EN
    logic             cfg_inv;
`endif

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
`ifdef PHASE_SHIFT_INV_EN
        output cfg_inv,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
`ifdef PHASE_SHIFT_INV_EN
        input  cfg_inv,
`endif
        output cfg_ready
    );
endinterface

// File: rtl/phase_shift_bank.sv
// rtl/phase_shift_bank.sv - sync-aligned counter-based clock divide/duty/phase bank (optional PHASE_SHIFT_INV_EN)
module phase_shift_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 RST_N,
    input  logic                 PWRDWN,
    input  logic                 sync,
    phase_shift_bank_if.slave    cfg,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    lock
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RUN} ch_state_t;

    logic r_ready;
    logic w_wr_en;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) r_ready <= 1'b0;
        else        r_ready <= !PWRDWN;
    end

    assign cfg.cfg_ready = r_ready;
    assign w_wr_en       = cfg.cfg_valid && r_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_sh_div, r_sh_high, r_sh_phase;
        logic [CNT_W-1:0] r_div, r_high, r_cnt;
        logic [CNT_W-1:0] w_sh_div_nx, w_sh_high_nx, w_sh_phase_nx;
        logic [CNT_W-1:0] w_div_nx, w_high_nx, w_cnt_nx, w_run_nx;
        ch_state_t        r_state, w_state_nx;
        logic             r_out, r_lock, w_out_nx, w_lock_nx;
        logic             w_sel, w_sh_ok, w_pol;

        // Out-of-range channel indices simply never match any channel.
        assign w_sel = w_wr_en && (cfg.cfg_ch == CH_W'(i));

        // Write-through: a write in the sync cycle is what sync loads.
        assign w_sh_div_nx   = w_sel ? cfg.cfg_div   : r_sh_div;
        assign w_sh_high_nx  = w_sel ? cfg.cfg_high  : r_sh_high;
        assign w_sh_phase_nx = w_sel ? cfg.cfg_phase : r_sh_phase;
        assign w_sh_ok       = (w_sh_div_nx != '0) && (w_sh_high_nx != '0)
                               && (w_sh_high_nx < w_sh_div_nx);
        assign w_run_nx      = (r_cnt == r_div - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);

`ifdef PHASE_SHIFT_INV_EN
        logic r_sh_inv, r_inv, w_sh_inv_nx;
        assign w_sh_inv_nx = w_sel ? cfg.cfg_inv : r_sh_inv;
        assign w_pol       = sync ? w_sh_inv_nx : r_inv;

        always_ff @(posedge clk or negedge RST_N) begin
            if (!RST_N) begin
                r_sh_inv <= 1'b0;
                r_inv    <= 1'b0;
            end else begin
                r_sh_inv <= w_sh_inv_nx;
                if (sync && !PWRDWN) r_inv <= w_sh_inv_nx;
            end
        end
`else
        assign w_pol = 1'b0;
`endif

        always_ff @(posedge clk or negedge RST_N) begin
            if (!RST_N) begin
                r_sh_div   <= CNT_W'(2);
                r_sh_high  <= CNT_W'(1);
                r_sh_phase <= '0;
            end else begin
                r_sh_div   <= w_sh_div_nx;
                r_sh_high  <= w_sh_high_nx;
                r_sh_phase <= w_sh_phase_nx;
            end
        end

        always_ff @(posedge clk or negedge RST_N) begin
            if (!RST_N) begin
                r_state <= ST_OFF;
                r_div   <= CNT_W'(2);
                r_high  <= CNT_W'(1);
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_lock  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_div   <= w_div_nx;
                r_high  <= w_high_nx;
                r_cnt   <= w_cnt_nx;
                r_out   <= w_out_nx;
                r_lock  <= w_lock_nx;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_div_nx   = r_div;
            w_high_nx  = r_high;
            w_cnt_nx   = r_cnt;
            w_out_nx   = 1'b0;
            w_lock_nx  = r_lock;
            if (PWRDWN) begin
                w_state_nx = ST_OFF;
                w_lock_nx  = 1'b0;
            end else if (sync) begin
                w_div_nx  = w_sh_div_nx;
                w_high_nx = w_sh_high_nx;
                w_lock_nx = 1'b0;
                if (!w_sh_ok) begin
                    w_state_nx = ST_OFF;
                end else if (w_sh_phase_nx == '0) begin
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = '0;
                    w_out_nx   = !w_pol;
                end else begin
                    w_state_nx = ST_WAIT;
                    w_cnt_nx   = w_sh_phase_nx;
                end
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_nx = ST_RUN;
                            w_cnt_nx   = '0;
                            w_out_nx   = !w_pol;
                        end else begin
                            w_cnt_nx = r_cnt - CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        w_cnt_nx = w_run_nx;
                        w_out_nx = (w_run_nx < r_high) ^ w_pol;
                        if (w_run_nx == '0) w_lock_nx = 1'b1;
                    end
                    default: begin
                        w_state_nx = ST_OFF;
                        w_lock_nx  = 1'b0;
                    end
                endcase
            end
        end

        assign clk_out[i] = r_out;
        assign lock[i]    = r_lock;
    end
endmodule

// File: tb/tb_phase_shift_bank.sv
// tb/tb_phase_shift_bank.sv - directed self-checking bench for phase_shift_bank
module tb_phase_shift_bank;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              RST_N;
    logic              PWRDWN;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] lock;

    int n_checks = 0;
    int n_fail   = 0;

    int e_div   [NUM_CH];
    int e_high  [NUM_CH];
    int e_phase [NUM_CH];

    phase_shift_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

    phase_shift_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .RST_N   (RST_N),
        .PWRDWN  (PWRDWN),
        .sync    (sync),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .lock    (lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int dv, input int hi, input int ph);
        cfg_bus.cfg_ch    = ch[1:0];
        cfg_bus.cfg_div   = dv[7:0];
        cfg_bus.cfg_high  = hi[7:0];
        cfg_bus.cfg_phase = ph[7:0];
    endtask

    task automatic write_cfg(input int ch, input int dv, input int hi, input int ph);
        set_cfg(ch, dv, hi, ph);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        e_div[ch]   = dv;
        e_high[ch]  = hi;
        e_phase[ch] = ph;
    endtask

    // Caller raises sync (and optionally a write); k counts cycles after the sync edge.
    task automatic run_window(input string name, input int len);
        logic [NUM_CH-1:0] eo, el;
        tick();
        sync              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit ok;
                ok    = (e_div[c] != 0) && (e_high[c] != 0) && (e_high[c] < e_div[c]);
                eo[c] = ok && (k >= e_phase[c]) && (((k - e_phase[c]) % e_div[c]) < e_high[c]);
                el[c] = ok && (k >= e_phase[c] + e_div[c]);
            end
            check($sformatf("%s clk_out k=%0d", name, k), 32'(clk_out), 32'(eo));
            check($sformatf("%s lock k=%0d", name, k), 32'(lock), 32'(el));
            tick();
        end
    endtask

    initial begin
        RST_N  = 1'b0;
        PWRDWN = 1'b0;
        sync   = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0);
`ifdef PHASE_SHIFT_INV_EN
        cfg_bus.cfg_inv = 1'b0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            e_div[c] = 2; e_high[c] = 1; e_phase[c] = 0;
        end

        tick();
        tick();
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset lock", 32'(lock), 32'h0);
        check("reset cfg_ready", 32'(cfg_bus.cfg_ready), 32'h0);
        RST_N = 1'b1;
        tick();
        check("ready after release", 32'(cfg_bus.cfg_ready), 32'h1);
        check("off before sync", 32'(clk_out), 32'h0);

        sync = 1'b1;
        run_window("default", 6);

        write_cfg(0, 8, 2, 3);
        write_cfg(1, 8, 4, 0);
        write_cfg(2, 5, 5, 0);
        tick();
        check("shadow not active yet", 32'(lock), 32'hF);
        sync = 1'b1;
        run_window("mixed", 13);

        set_cfg(0, 8, 2, 6);
        cfg_bus.cfg_valid = 1'b1;
        e_phase[0] = 6;
        sync = 1'b1;
        run_window("write-through", 16);

        write_cfg(1, 6, 3, 0);
        tick();
        check("lock held before resync", 32'(lock[1]), 32'h1);
        sync = 1'b1;
        run_window("resync div", 16);

        PWRDWN = 1'b1;
        tick();
        check("pwrdwn clk_out", 32'(clk_out), 32'h0);
        check("pwrdwn lock", 32'(lock), 32'h0);
        check("pwrdwn cfg_ready", 32'(cfg_bus.cfg_ready), 32'h0);
        set_cfg(3, 4, 2, 0);
        cfg_bus.cfg_valid = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        check("pwrdwn hold clk_out", 32'(clk_out), 32'h0);
        check("pwrdwn hold ready", 32'(cfg_bus.cfg_ready), 32'h0);
        cfg_bus.cfg_valid = 1'b0;
        PWRDWN = 1'b0;
        tick();
        check("ready after pwrup", 32'(cfg_bus.cfg_ready), 32'h1);
        tick();
        tick();
        check("off after pwrup", 32'(clk_out), 32'h0);
        check("unlocked after pwrup", 32'(lock), 32'h0);
        sync = 1'b1;
        run_window("resume", 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/phase_shift_bank.md
# phase_shift_bank

Multi-channel, counter-based clock phase/divide/duty generator for the PLL simulation models. It replaces per-output delay-based shifting with cycle-exact counters clocked by the VCO-rate clock `clk`. It produces `NUM_CH` independently configured outputs whose phase is defined relative to a common `sync` event, so relative phase between channels is deterministic. Configuration is double-buffered: writes land in shadow registers and take effect only at `sync`.

## Interface
- `NUM_CH`, default 4: number of output channels (1..16).
- `CNT_W`, default 8: width of divide, high-time and phase fields.
- `clk` input 1: VCO-rate clock; all logic on its rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `PWRDWN` input 1: synchronous power-down, level sensitive.
- `sync` input 1: one-cycle pulse; loads shadow config into all channels and realigns them.
- `cfg_valid` input 1: config write request.
- `cfg_ready` output 1: `!PWRDWN`, registered; a write completes when `cfg_valid && cfg_ready`.
- `cfg_ch` input `$clog2(NUM_CH)` (min 1): target channel. Out-of-range indices are ignored.
- `cfg_div` input `CNT_W`: period in `clk` cycles.
- `cfg_high` input `CNT_W`: high time in `clk` cycles.
- `cfg_phase` input `CNT_W`: delay in `clk` cycles from `sync` to the first rising edge.
- `clk_out` output `NUM_CH`: generated clocks, registered.
- `lock` output `NUM_CH`: per-channel lock, registered.

## Operation
- **Reset**
  - Shadow and active registers become `div=2`, `high=1`, `phase=0`.
  - All channels go to state OFF; `clk_out=0`, `lock=0`, `cfg_ready=0`.
  - `cfg_ready` becomes 1 on the first edge after reset release when `PWRDWN=0`.
- **Per-channel states**
  - OFF: output 0, `lock` 0.
  - WAIT: phase down-counter running; output 0.
  - RUN: period counter `cnt` cycles 0..`div-1`; output `= (cnt < high)`.
- **Transitions**
  - `sync` in any state: copy shadow to active, clear `lock`.
  - If the config is invalid, go to OFF. Invalid means `div==0`, `high==0` or `high>=div`.
  - Otherwise, if `phase==0`, go to RUN with `cnt=0`.
  - Otherwise go to WAIT with the counter at `phase`.
  - WAIT: decrement each cycle; at 1, go to RUN with `cnt=0`.
  - RUN: when `cnt` wraps from `div-1` to 0, set `lock`. `lock` stays set until the next `sync`, `PWRDWN` or reset.
- **Simultaneous write and `sync`:** the write is applied to the shadow and the same `sync` loads the new value (write-through).
- **`sync` during RUN/WAIT:** immediate realignment. The current pulse may be truncated; no glitch shorter than 1 cycle is produced.
- **`PWRDWN=1`**
  - All channels go to OFF, `clk_out=0`, `lock=0`; writes are blocked.
  - Shadow registers are retained.
  - After deassertion, channels stay OFF until the next `sync`.
- **Arithmetic:** all counters are unsigned `CNT_W` bits; there is no wrap beyond the field ranges.

## Timing
- `sync` sampled at edge T, valid config:
  - `clk_out` rises at edge T+`phase`.
  - It stays high `high` cycles, with period `div`.
  - `lock` rises at edge T+`phase`+`div`, coincident with the second rising edge.
- Config write at edge W is visible to a `sync` at edge ≥ W (same edge included).
- `PWRDWN` asserted at edge P: outputs are 0 from edge P. `cfg_ready` drops at edge P.
- Output duty = `high/div`; the minimum period is 2 cycles (`div=2`, `high=1`).

## Configuration
- `PHASE_SHIFT_INV_EN` defined:
  - Adds input `cfg_inv` (1 bit) to the write interface and a per-channel shadow/active invert bit (reset 0).
  - In RUN, the channel's `clk_out` is inverted (low for `high` cycles, then high).
  - OFF/WAIT output remains 0; `lock` timing is unchanged.
- `PHASE_SHIFT_INV_EN` undefined: the port and the bits are absent, and the output is never inverted.

## Test plan
- Reset, then `sync` with default config → all channels toggle with period 2 starting at the `sync` edge; `lock` asserts 2 cycles later.
- ch0 `div=8`, `high=2`, `phase=3`; ch1 `div=8`, `high=4`, `phase=0`; `sync` at T → ch1 rises at T, ch0 at T+3; ch0 `lock` at T+11, ch1 `lock` at T+8.
- ch2 `div=5`, `high=5` (invalid), then `sync` → ch2 stays 0 and unlocked; other channels are unaffected.
- Write ch0 `phase=6` in the same cycle as `sync` → the new phase is applied: ch0 rises at T+6.
- Mid-RUN `sync` with changed `div` → `lock` drops at the `sync` edge and re-locks after the new `phase`+`div`.
- `PWRDWN` high for 10 cycles during RUN → outputs 0, `cfg_ready` 0, writes ignored; after release, outputs stay 0 until `sync`, then resume with the retained shadow config.
